nvdla_rubik_cmd_fifo_p: RTL and testbench
=========================================

Name: nvdla_rubik_cmd_fifo_p

Overview:
- Parametrised synchronous command FIFO for the RUBIK write-command path. It is the successor to the fixed 256x11 wcmd FIFO.
- Width, depth and almost-full level are generics.
- Adds features the fixed FIFO lacks: a run-time write limit port (replacing the simulation plusarg), a synchronous flush, and occupancy status outputs (count, almost-full, sticky peak).
- Sits between the RUBIK command generator (valid/ready producer) and the write DMA request logic (valid/ready consumer).

Parameters:
- DW, 11, payload width in bits (>=1).
- DEPTH, 256, number of entries; power of two, >=2.
- AF_LEVEL, 240, almost_full asserts when count >= AF_LEVEL; 1 <= AF_LEVEL <= DEPTH.
- Derived: AW = log2(DEPTH); CW = AW+1.

Ports:
- nvdla_core_clk  input  1  single clock, all flops rising edge.
- nvdla_core_rst  input  1  reset, synchronous, active-high.
- idata_pvld  input  1  write valid.
- idata_prdy  output  1  write ready.
- idata_pd  input  DW  write payload.
- odata_pvld  output  1  read valid.
- odata_prdy  input  1  read ready.
- odata_pd  output  DW  read payload.
- fifo_flush  input  1  synchronous flush request, one or more cycles.
- wr_limit  input  CW  run-time occupancy limit; 0 means DEPTH.
- fifo_count  output  CW  current occupancy, registered.
- fifo_almost_full  output  1  fifo_count >= AF_LEVEL, registered.
- fifo_peak  output  CW  sticky high-water mark of fifo_count.

Behaviour:
- Reset: one clock and a synchronous active-high reset; all state updates on the rising edge of nvdla_core_clk while nvdla_core_rst is high.
- Reset values: count=0, read and write pointers=0, odata_pvld=0, fifo_count=0, fifo_almost_full=0, fifo_peak=0. idata_prdy=0 while reset is high.
- odata_pd is don't-care while odata_pvld=0. The bench must not check it.
- Push condition: idata_pvld & idata_prdy. Pop condition: odata_pvld & odata_prdy.
- Effective limit: lim = (wr_limit==0 || wr_limit>DEPTH) ? DEPTH : wr_limit. Evaluated every cycle.
- idata_prdy = !rst & !fifo_flush & (count < lim).
  - Depends only on registered count, wr_limit and fifo_flush.
  - No combinational path from odata_prdy.
  - Space freed by a pop becomes visible the following cycle.
- Lowering wr_limit below the current count never drops entries. It only holds idata_prdy low until the FIFO drains below lim.
- Latency: an entry pushed in cycle N into an empty FIFO gives odata_pvld=1 with that payload in cycle N+1. No same-cycle bypass.
- Output stability: while odata_pvld=1 and odata_prdy=0, odata_pvld and odata_pd stay stable.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Empty plus push: pop is impossible that cycle.
- Full plus pop: push is impossible that cycle, because idata_prdy was already low.
- count saturates at neither end: overflow and underflow are structurally impossible. An assertion flags any attempt.
- odata_pvld = (count != 0) after the registered update, i.e. registered.
- Flush, in any cycle fifo_flush=1:
  - any concurrent push is rejected (idata_prdy=0);
  - any concurrent pop is completed from the consumer's view, but is irrelevant;
  - next cycle: count=0, pointers=0, odata_pvld=0, fifo_count=0, fifo_almost_full=0;
  - fifo_peak is preserved, not cleared by flush.
- Peak tracking: fifo_peak <= max(fifo_peak, next count) each cycle. Cleared only by reset.
- fifo_count and fifo_almost_full reflect the count after the current cycle's push/pop, registered, i.e. aligned with odata_pvld.
- Reset mid-operation: the next edge restores all reset values. In-flight data is discarded.

Test Plan:
- Basic ordering (DEPTH=4, DW=11): push 0x001,0x002,0x003 back-to-back with odata_prdy=1 -> odata_pvld first high one cycle after the 0x001 push; outputs 0x001,0x002,0x003 on consecutive cycles; fifo_count peaks at 1; fifo_peak=1.
- Full (DEPTH=4, wr_limit=0): push 4 words with odata_prdy=0 -> idata_prdy=0 after the 4th push; fifo_count=4; fifo_almost_full=1 with AF_LEVEL=3. Single pop -> idata_prdy=1 the following cycle, not the same cycle. A further push wraps the write pointer to entry 0 and data order is preserved.
- Run-time limit (DEPTH=8, wr_limit=2): push continuously with odata_prdy=0 -> exactly 2 accepted, idata_prdy=0, fifo_count=2. Change wr_limit to 5 -> 3 more accepted. wr_limit=9 -> treated as 8.
- Simultaneous push/pop at count=2 for 10 cycles -> fifo_count stays 2; output sequence equals input sequence delayed by 2.
- Flush: fill 3 entries (peak 3), assert fifo_flush with idata_pvld=1 -> push rejected; next cycle odata_pvld=0, fifo_count=0, fifo_peak=3. A subsequent push of 0x7FF appears as the first output.
- Backpressure stability plus reset: hold odata_prdy=0 for 5 cycles with odata_pvld=1 -> odata_pd unchanged. Assert nvdla_core_rst for 1 cycle with 3 entries stored -> next cycle all outputs at reset values, including fifo_peak=0.

Source files
------------

// File: rtl/nvdla_rubik_cmd_fifo_p_if.sv
// nvdla_rubik_cmd_fifo_p_if: producer/consumer handshake, flush, limit and status bundle for the command FIFO
interface nvdla_rubik_cmd_fifo_p_if #(
    parameter int DW = 11,
    parameter int CW = 9
);
    logic          idata_pvld;
    logic          idata_prdy;
    logic [DW-1:0] idata_pd;
    logic          odata_pvld;
    logic          odata_prdy;
    logic [DW-1:0] odata_pd;
    logic          fifo_flush;
    logic [CW-1:0] wr_limit;
    logic [CW-1:0] fifo_count;
    logic          fifo_almost_full;
    logic [CW-1:0] fifo_peak;

    modport master (
        output idata_pvld, idata_pd, odata_prdy, fifo_flush, wr_limit,
        input  idata_prdy, odata_pvld, odata_pd, fifo_count, fifo_almost_full, fifo_peak
    );
    modport slave (
        input  idata_pvld, idata_pd, odata_prdy, fifo_flush, wr_limit,
        output idata_prdy, odata_pvld, odata_pd, fifo_count, fifo_almost_full, fifo_peak
    );
endinterface

// File: rtl/nvdla_rubik_cmd_fifo_p.sv
// nvdla_rubik_cmd_fifo_p: parametrised command FIFO with run-time write limit, flush and occupancy status
module nvdla_rubik_cmd_fifo_p #(
    parameter int DW       = 11,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = 240
) (
    input logic                    nvdla_core_clk,
    input logic                    nvdla_core_rst,
    nvdla_rubik_cmd_fifo_p_if.slave io
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d, peak_q, peak_d, lim;
    logic          af_q, af_d, push, pop, prdy;

    always_comb begin
        lim    = (io.wr_limit == '0 || io.wr_limit > CW'(DEPTH)) ? CW'(DEPTH) : io.wr_limit;
        prdy   = !nvdla_core_rst && !io.fifo_flush && cnt_q < lim;
        push   = io.idata_pvld && prdy;
        pop    = cnt_q != '0 && io.odata_prdy;
        wp_d   = io.fifo_flush ? '0 : wp_q + AW'(push);
        rp_d   = io.fifo_flush ? '0 : rp_q + AW'(pop);
        cnt_d  = io.fifo_flush ? '0 : cnt_q + CW'(push) - CW'(pop);
        af_d   = cnt_d >= CW'(AF_LEVEL);
        peak_d = cnt_d > peak_q ? cnt_d : peak_q;
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            af_q   <= 1'b0;
            peak_q <= '0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            af_q   <= af_d;
            peak_q <= peak_d;
        end
    end

    // Storage needs no reset: entries are only observable once counted.
    always_ff @(posedge nvdla_core_clk) begin
        if (push) mem_q[wp_q] <= io.idata_pd;
    end

    assign io.idata_prdy       = prdy;
    assign io.odata_pvld       = cnt_q != '0;
    assign io.odata_pd         = mem_q[rp_q];
    assign io.fifo_count       = cnt_q;
    assign io.fifo_almost_full = af_q;
    assign io.fifo_peak        = peak_q;

    a_no_overflow: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        !(push && !pop && cnt_q == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        !(pop && !push && cnt_q == '0));
endmodule

// File: tb/tb_nvdla_rubik_cmd_fifo_p.sv
// tb_nvdla_rubik_cmd_fifo_p: directed and random checks of two FIFO configurations against a queue model
module tb_nvdla_rubik_cmd_fifo_p;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [10:0] qa[$];
    logic [10:0] qb[$];
    int pka = 0;
    int pkb = 0;

    nvdla_rubik_cmd_fifo_p_if #(.DW(11), .CW(3)) a_if ();
    nvdla_rubik_cmd_fifo_p_if #(.DW(11), .CW(4)) b_if ();

    nvdla_rubik_cmd_fifo_p #(.DW(11), .DEPTH(4), .AF_LEVEL(3)) u_a (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .io(a_if.slave));
    nvdla_rubik_cmd_fifo_p #(.DW(11), .DEPTH(8), .AF_LEVEL(6)) u_b (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .io(b_if.slave));

    always #5 clk = ~clk;

    function automatic int lim(int wl, int d);
        return (wl == 0 || wl > d) ? d : wl;
    endfunction

    // One clock: decide pushes/pops from pre-edge inputs, then update the queues.
    task automatic cyc();
        bit pa, oa, pb, ob;
        logic [10:0] da, db;
        pa = !rst && !a_if.fifo_flush && a_if.idata_pvld && qa.size() < lim(int'(a_if.wr_limit), 4);
        oa = qa.size() != 0 && a_if.odata_prdy;
        pb = !rst && !b_if.fifo_flush && b_if.idata_pvld && qb.size() < lim(int'(b_if.wr_limit), 8);
        ob = qb.size() != 0 && b_if.odata_prdy;
        da = a_if.idata_pd;
        db = b_if.idata_pd;
        @(posedge clk);
        if (rst) begin
            qa.delete(); qb.delete(); pka = 0; pkb = 0;
        end else begin
            if (a_if.fifo_flush) qa.delete();
            else begin
                if (oa) void'(qa.pop_front());
                if (pa) qa.push_back(da);
            end
            if (b_if.fifo_flush) qb.delete();
            else begin
                if (ob) void'(qb.pop_front());
                if (pb) qb.push_back(db);
            end
            if (qa.size() > pka) pka = qa.size();
            if (qb.size() > pkb) pkb = qb.size();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        checks++; if ({a_if.idata_prdy, a_if.odata_pvld, a_if.fifo_count, a_if.fifo_almost_full, a_if.fifo_peak} !== '0) begin
            errors++; $display("FAIL reset_a got prdy=%b vld=%b cnt=%0d af=%b pk=%0d want all 0", a_if.idata_prdy, a_if.odata_pvld, a_if.fifo_count, a_if.fifo_almost_full, a_if.fifo_peak); end
        checks++; if ({b_if.idata_prdy, b_if.odata_pvld, b_if.fifo_count, b_if.fifo_almost_full, b_if.fifo_peak} !== '0) begin
            errors++; $display("FAIL reset_b got prdy=%b vld=%b cnt=%0d af=%b pk=%0d want all 0", b_if.idata_prdy, b_if.odata_pvld, b_if.fifo_count, b_if.fifo_almost_full, b_if.fifo_peak); end
        rst = 1'b0;
        #1;
        checks++; if (a_if.idata_prdy !== 1'b1) begin errors++; $display("FAIL post_reset_prdy got %b want 1", a_if.idata_prdy); end
    endtask

    task automatic test_basic();
        a_if.odata_prdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_if.idata_pvld = 1'b1;
            a_if.idata_pd = 11'(i + 1);
            #1;
            checks++; if (a_if.idata_prdy !== 1'b1) begin errors++; $display("FAIL basic_prdy[%0d] got %b want 1", i, a_if.idata_prdy); end
            cyc();
            checks++; if (a_if.odata_pvld !== 1'b1 || a_if.odata_pd !== 11'(i + 1)) begin
                errors++; $display("FAIL basic_out[%0d] got vld=%b pd=%h want 1 %h", i, a_if.odata_pvld, a_if.odata_pd, i + 1); end
            checks++; if (a_if.fifo_count !== 1) begin errors++; $display("FAIL basic_cnt[%0d] got %0d want 1", i, a_if.fifo_count); end
        end
        a_if.idata_pvld = 1'b0;
        cyc();
        checks++; if (a_if.odata_pvld !== 1'b0 || a_if.fifo_count !== 0) begin
            errors++; $display("FAIL basic_drain got vld=%b cnt=%0d want 0 0", a_if.odata_pvld, a_if.fifo_count); end
        checks++; if (a_if.fifo_peak !== 1) begin errors++; $display("FAIL basic_peak got %0d want 1", a_if.fifo_peak); end
    endtask

    task automatic test_flush();
        a_if.odata_prdy = 1'b0;
        a_if.idata_pvld = 1'b1;
        repeat (3) begin a_if.idata_pd = 11'($urandom); cyc(); end
        checks++; if (a_if.fifo_peak !== 3 || a_if.fifo_count !== 3) begin
            errors++; $display("FAIL flush_fill got pk=%0d cnt=%0d want 3 3", a_if.fifo_peak, a_if.fifo_count); end
        a_if.fifo_flush = 1'b1;
        a_if.idata_pd = 11'h123;
        #1;
        checks++; if (a_if.idata_prdy !== 1'b0) begin errors++; $display("FAIL flush_prdy got %b want 0", a_if.idata_prdy); end
        cyc();
        checks++; if (a_if.odata_pvld !== 1'b0 || a_if.fifo_count !== 0 || a_if.fifo_almost_full !== 1'b0 || a_if.fifo_peak !== 3) begin
            errors++; $display("FAIL flush_after got vld=%b cnt=%0d af=%b pk=%0d want 0 0 0 3", a_if.odata_pvld, a_if.fifo_count, a_if.fifo_almost_full, a_if.fifo_peak); end
        a_if.fifo_flush = 1'b0;
        a_if.idata_pd = 11'h7FF;
        cyc();
        a_if.idata_pvld = 1'b0;
        checks++; if (a_if.odata_pvld !== 1'b1 || a_if.odata_pd !== 11'h7FF) begin
            errors++; $display("FAIL flush_first got vld=%b pd=%h want 1 7ff", a_if.odata_pvld, a_if.odata_pd); end
        a_if.odata_prdy = 1'b1;
        cyc();
        checks++; if (a_if.odata_pvld !== 1'b0) begin errors++; $display("FAIL flush_drain got %b want 0", a_if.odata_pvld); end
    endtask

    task automatic test_full();
        a_if.wr_limit = '0;
        a_if.odata_prdy = 1'b0;
        a_if.idata_pvld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_if.idata_pd = 11'($urandom);
            #1;
            checks++; if (a_if.idata_prdy !== 1'b1) begin errors++; $display("FAIL full_prdy[%0d] got %b want 1", i, a_if.idata_prdy); end
            cyc();
        end
        checks++; if (a_if.idata_prdy !== 1'b0 || a_if.fifo_count !== 4 || a_if.fifo_almost_full !== 1'b1 || a_if.fifo_peak !== 4) begin
            errors++; $display("FAIL full_state got prdy=%b cnt=%0d af=%b pk=%0d want 0 4 1 4", a_if.idata_prdy, a_if.fifo_count, a_if.fifo_almost_full, a_if.fifo_peak); end
        a_if.odata_prdy = 1'b1;
        a_if.idata_pd = 11'h555;
        #1;
        checks++; if (a_if.idata_prdy !== 1'b0) begin errors++; $display("FAIL full_pop_same got %b want 0", a_if.idata_prdy); end
        cyc();
        checks++; if (a_if.idata_prdy !== 1'b1 || a_if.fifo_count !== 3) begin
            errors++; $display("FAIL full_pop_next got prdy=%b cnt=%0d want 1 3", a_if.idata_prdy, a_if.fifo_count); end
        a_if.odata_prdy = 1'b0;
        a_if.idata_pd = 11'h2AA;
        cyc();
        a_if.idata_pvld = 1'b0;
        a_if.odata_prdy = 1'b1;
        for (int k = 0; k < 8 && qa.size() != 0; k++) begin
            checks++; if (a_if.odata_pvld !== 1'b1 || a_if.odata_pd !== qa[0]) begin
                errors++; $display("FAIL full_order[%0d] got vld=%b pd=%h want 1 %h", k, a_if.odata_pvld, a_if.odata_pd, qa[0]); end
            cyc();
        end
        checks++; if (a_if.odata_pvld !== 1'b0 || a_if.fifo_count !== 0) begin
            errors++; $display("FAIL full_drain got vld=%b cnt=%0d want 0 0", a_if.odata_pvld, a_if.fifo_count); end
    endtask

    task automatic test_bp_reset();
        logic [10:0] f;
        a_if.odata_prdy = 1'b0;
        a_if.idata_pvld = 1'b1;
        f = 11'($urandom);
        a_if.idata_pd = f;
        cyc();
        repeat (2) begin a_if.idata_pd = 11'($urandom); cyc(); end
        a_if.idata_pvld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++; if (a_if.odata_pvld !== 1'b1 || a_if.odata_pd !== f) begin
                errors++; $display("FAIL bp_hold[%0d] got vld=%b pd=%h want 1 %h", i, a_if.odata_pvld, a_if.odata_pd, f); end
        end
        rst = 1'b1;
        cyc();
        checks++; if ({a_if.idata_prdy, a_if.odata_pvld, a_if.fifo_count, a_if.fifo_almost_full, a_if.fifo_peak} !== '0) begin
            errors++; $display("FAIL mid_reset got prdy=%b vld=%b cnt=%0d af=%b pk=%0d want all 0", a_if.idata_prdy, a_if.odata_pvld, a_if.fifo_count, a_if.fifo_almost_full, a_if.fifo_peak); end
        rst = 1'b0;
    endtask

    task automatic test_limit();
        int n;
        b_if.odata_prdy = 1'b0;
        b_if.idata_pvld = 1'b1;
        for (int s = 0; s < 3; s++) begin
            b_if.wr_limit = (s == 0) ? 4'd2 : (s == 1) ? 4'd5 : 4'd9;
            n = 0;
            repeat (6) begin
                b_if.idata_pd = 11'($urandom);
                #1;
                if (b_if.idata_prdy === 1'b1) n++;
                cyc();
            end
            checks++; if (n != ((s == 0) ? 2 : 3) || b_if.fifo_count !== ((s == 0) ? 2 : (s == 1) ? 5 : 8) || b_if.idata_prdy !== 1'b0) begin
                errors++; $display("FAIL limit_step%0d got acc=%0d cnt=%0d prdy=%b", s, n, b_if.fifo_count, b_if.idata_prdy); end
        end
        b_if.wr_limit = 4'd3;
        repeat (2) cyc();
        checks++; if (b_if.fifo_count !== 8 || b_if.idata_prdy !== 1'b0) begin
            errors++; $display("FAIL limit_lower got cnt=%0d prdy=%b want 8 0", b_if.fifo_count, b_if.idata_prdy); end
        b_if.idata_pvld = 1'b0;
        b_if.odata_prdy = 1'b1;
        for (int k = 0; k < 12 && qb.size() != 0; k++) begin
            checks++; if (b_if.odata_pvld !== 1'b1 || b_if.odata_pd !== qb[0]) begin
                errors++; $display("FAIL limit_order[%0d] got vld=%b pd=%h want 1 %h", k, b_if.odata_pvld, b_if.odata_pd, qb[0]); end
            cyc();
        end
        checks++; if (b_if.fifo_count !== 0) begin errors++; $display("FAIL limit_drain got %0d want 0", b_if.fifo_count); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] s [12];
        for (int i = 0; i < 12; i++) s[i] = 11'($urandom);
        b_if.wr_limit = '0;
        b_if.odata_prdy = 1'b0;
        b_if.idata_pvld = 1'b1;
        for (int i = 0; i < 2; i++) begin b_if.idata_pd = s[i]; cyc(); end
        b_if.odata_prdy = 1'b1;
        for (int i = 2; i < 12; i++) begin
            b_if.idata_pd = s[i];
            checks++; if (b_if.odata_pd !== s[i-2]) begin errors++; $display("FAIL b2b_pd[%0d] got %h want %h", i, b_if.odata_pd, s[i-2]); end
            cyc();
            checks++; if (b_if.fifo_count !== 2) begin errors++; $display("FAIL b2b_cnt[%0d] got %0d want 2", i, b_if.fifo_count); end
        end
        b_if.idata_pvld = 1'b0;
        for (int i = 10; i < 12; i++) begin
            checks++; if (b_if.odata_pvld !== 1'b1 || b_if.odata_pd !== s[i]) begin
                errors++; $display("FAIL b2b_tail[%0d] got vld=%b pd=%h want 1 %h", i, b_if.odata_pvld, b_if.odata_pd, s[i]); end
            cyc();
        end
    endtask

    task automatic test_random();
        bit ep;
        for (int i = 0; i < 400; i++) begin
            a_if.idata_pvld = 1'($urandom_range(0, 1));
            a_if.idata_pd = 11'($urandom);
            a_if.odata_prdy = ($urandom_range(0, 3) != 0);
            a_if.fifo_flush = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 20) == 0) a_if.wr_limit = 3'($urandom_range(0, 7));
            #1;
            ep = !a_if.fifo_flush && qa.size() < lim(int'(a_if.wr_limit), 4);
            checks++; if (a_if.idata_prdy !== ep) begin errors++; $display("FAIL rnd_prdy[%0d] got %b want %b", i, a_if.idata_prdy, ep); end
            cyc();
            checks++; if (a_if.odata_pvld !== (qa.size() != 0) || a_if.fifo_count !== qa.size() || a_if.fifo_almost_full !== (qa.size() >= 3) || a_if.fifo_peak !== pka) begin
                errors++; $display("FAIL rnd_state[%0d] got vld=%b cnt=%0d af=%b pk=%0d want cnt=%0d pk=%0d", i, a_if.odata_pvld, a_if.fifo_count, a_if.fifo_almost_full, a_if.fifo_peak, qa.size(), pka); end
            if (qa.size() != 0) begin
                checks++; if (a_if.odata_pd !== qa[0]) begin errors++; $display("FAIL rnd_pd[%0d] got %h want %h", i, a_if.odata_pd, qa[0]); end
            end
        end
        a_if.fifo_flush = 1'b0;
    endtask

    initial begin
        a_if.idata_pvld = 1'b0; a_if.idata_pd = '0; a_if.odata_prdy = 1'b0; a_if.fifo_flush = 1'b0; a_if.wr_limit = '0;
        b_if.idata_pvld = 1'b0; b_if.idata_pd = '0; b_if.odata_prdy = 1'b0; b_if.fifo_flush = 1'b0; b_if.wr_limit = '0;
        test_reset();
        test_basic();
        test_flush();
        test_full();
        test_bp_reset();
        test_limit();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
